// File: rtl/serial_sub_ctrl.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell is stepped over the
// operands LSB first, with the borrow kept in a flip-flop between bit positions.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] RUN  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state_r;
    logic [WIDTH-1:0] a_sh_r;
    logic [WIDTH-1:0] b_sh_r;
    logic [WIDTH-1:0] res_r;
    logic             brw_r;
    logic [CW-1:0]    cnt_r;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] diff_r;
    logic             borrow_out_r;

    logic [1:0]       cell_s;
    logic [WIDTH-1:0] res_next_s;
    logic             last_s;

    // Full-subtractor cell; returns {borrow_out, difference}.
    function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bi);
        logic d;
        logic bo;
        d  = x ^ y ^ bi;
        bo = (~x & y) | (~(x ^ y) & bi);
        return {bo, d};
    endfunction

    // Cell evaluation on the current LSBs and the next result-shift value.
    always_comb begin
        cell_s     = full_sub(a_sh_r[0], b_sh_r[0], brw_r);
        res_next_s = {cell_s[0], res_r[WIDTH-1:1]};
        last_s     = (cnt_r == CW'(WIDTH - 1));
    end

    // Control FSM, operand shifters, borrow flop and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            a_sh_r       <= {WIDTH{1'b0}};
            b_sh_r       <= {WIDTH{1'b0}};
            res_r        <= {WIDTH{1'b0}};
            brw_r        <= 1'b0;
            cnt_r        <= {CW{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            diff_r       <= {WIDTH{1'b0}};
            borrow_out_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_sh_r  <= a;
                        b_sh_r  <= b;
                        brw_r   <= bin;
                        cnt_r   <= {CW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    res_r  <= res_next_s;
                    a_sh_r <= {1'b0, a_sh_r[WIDTH-1:1]};
                    b_sh_r <= {1'b0, b_sh_r[WIDTH-1:1]};
                    brw_r  <= cell_s[1];
                    // The last bit lands straight in the outputs so they are valid with done.
                    if (last_s) begin
                        cnt_r        <= {CW{1'b0}};
                        diff_r       <= res_next_s;
                        borrow_out_r <= cell_s[1];
                        done_r       <= 1'b1;
                        state_r      <= DONE;
                    end else begin
                        cnt_r   <= cnt_r + CW'(1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy       = busy_r;
    assign done       = done_r;
    assign diff       = diff_r;
    assign borrow_out = borrow_out_r;

endmodule

// File: tb/tb_serial_sub_ctrl.sv
// Scoreboard bench for serial_sub_ctrl: WIDTH=8 directed vectors plus an
// exhaustive WIDTH=2 back-to-back run with start held high.
module tb_serial_sub_ctrl;

    typedef struct packed {
        logic [7:0] d;
        logic       bo;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;

    logic       start8 = 1'b0;
    logic [7:0] a8 = 8'h00, b8 = 8'h00;
    logic       bin8 = 1'b0;
    logic       busy8, done8, bo8;
    logic [7:0] diff8;

    logic       start2 = 1'b0;
    logic [1:0] a2 = 2'b00, b2 = 2'b00;
    logic       bin2 = 1'b0;
    logic       busy2, done2, bo2;
    logic [1:0] diff2;

    exp_t q8[$];
    exp_t q2[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   done_cnt8 = 0;
    int   cyc = 0;

    serial_sub_ctrl #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .bin(bin8),
        .busy(busy8), .done(done8), .diff(diff8), .borrow_out(bo8)
    );

    serial_sub_ctrl #(.WIDTH(2)) u2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a2), .b(b2), .bin(bin2),
        .busy(busy2), .done(done2), .diff(diff2), .borrow_out(bo2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor for the WIDTH=8 instance: pops the scoreboard on every done pulse.
    always @(negedge clk) begin
        if (done8 === 1'b1) begin
            exp_t e;
            done_cnt8++;
            if (q8.size() == 0) begin
                chk("w8_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q8.pop_front();
                chk("w8_diff", {24'd0, diff8}, {24'd0, e.d});
                chk("w8_borrow", {31'd0, bo8}, {31'd0, e.bo});
            end
        end
    end

    // Monitor for the WIDTH=2 instance.
    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            exp_t e;
            if (q2.size() == 0) begin
                chk("w2_unexpected_done", 32'd1, 32'd0);
            end else begin
                e = q2.pop_front();
                chk("w2_diff", {30'd0, diff2}, {30'd0, e.d[1:0]});
                chk("w2_borrow", {31'd0, bo2}, {31'd0, e.bo});
            end
        end
    end

    task automatic op8(input logic [7:0] ta, input logic [7:0] tb, input logic tbin,
                       input logic [7:0] ed, input logic eb, input bit poke);
        int  lat;
        int  busy_cycles;
        bit  seen;
        @(negedge clk);
        a8 = ta; b8 = tb; bin8 = tbin; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        chk("w8_accept_busy", {31'd0, busy8}, 32'd1);
        q8.push_back('{d: ed, bo: eb});
        busy_cycles = 1;
        lat = 0;
        seen = 1'b0;
        for (int k = 1; k <= 20 && !seen; k++) begin
            if (poke && k == 3) begin
                a8 = 8'hAA; start8 = 1'b1;
            end
            @(posedge clk); #1;
            start8 = 1'b0;
            if (busy8) busy_cycles++;
            if (done8) begin
                seen = 1'b1;
                lat = k + 1;
            end
        end
        chk("w8_done_latency", lat, 32'd9);
        chk("w8_busy_cycles", busy_cycles, 32'd9);
        @(posedge clk); #1;
        chk("w8_idle_busy", {31'd0, busy8}, 32'd0);
        chk("w8_idle_done", {31'd0, done8}, 32'd0);
    endtask

    initial begin
        int  dc;
        int  last_acc;
        bit  prev;
        bit  acc;
        logic [2:0] f;

        #1;
        chk("rst_busy", {31'd0, busy8}, 32'd0);
        chk("rst_done", {31'd0, done8}, 32'd0);
        chk("rst_diff", {24'd0, diff8}, 32'd0);
        chk("rst_borrow", {31'd0, bo8}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        op8(8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
        op8(8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
        op8(8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
        op8(8'hFF, 8'hFF, 1'b0, 8'h00, 1'b0, 1'b0);
        op8(8'h80, 8'h01, 1'b1, 8'h7E, 1'b0, 1'b0);

        dc = done_cnt8;
        op8(8'h10, 8'h01, 1'b0, 8'h0F, 1'b0, 1'b1);
        repeat (12) @(posedge clk);
        #1;
        chk("w8_single_done", done_cnt8, dc + 1);
        chk("w8_diff_hold", {24'd0, diff8}, 32'h0F);
        chk("w8_busy_after_poke", {31'd0, busy8}, 32'd0);

        // Abort in the fourth RUN cycle.
        @(negedge clk);
        a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q8.delete();
        dc = done_cnt8;
        #1;
        chk("abort_busy", {31'd0, busy8}, 32'd0);
        chk("abort_done", {31'd0, done8}, 32'd0);
        chk("abort_diff", {24'd0, diff8}, 32'd0);
        chk("abort_borrow", {31'd0, bo8}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (14) @(posedge clk);
        #1;
        chk("abort_no_done", done_cnt8, dc);
        op8(8'h5A, 8'h3C, 1'b1, 8'h1D, 1'b0, 1'b0);

        // WIDTH=2 exhaustive sweep, start held high throughout.
        prev = busy2;
        last_acc = 0;
        for (int i = 0; i < 32; i++) begin
            logic [4:0] iv;
            iv = 5'(i);
            a2 = iv[4:3]; b2 = iv[2:1]; bin2 = iv[0];
            start2 = 1'b1;
            f = {1'b0, a2} - {1'b0, b2} - {2'b00, bin2};
            acc = 1'b0;
            for (int k = 0; k < 8 && !acc; k++) begin
                @(posedge clk); #1;
                if (!prev && busy2) acc = 1'b1;
                prev = busy2;
            end
            if (!acc) begin
                chk("w2_accept_timeout", 32'd0, 32'd1);
            end else begin
                q2.push_back('{d: {6'd0, f[1:0]}, bo: f[2]});
                if (i > 0) chk("w2_spacing", cyc - last_acc, 32'd4);
                last_acc = cyc;
            end
            acc = 1'b0;
            for (int k = 0; k < 8 && !acc; k++) begin
                @(posedge clk); #1;
                prev = busy2;
                if (done2) acc = 1'b1;
            end
            if (!acc) chk("w2_done_timeout", 32'd0, 32'd1);
        end
        start2 = 1'b0;

        repeat (6) @(posedge clk);
        #1;
        chk("w8_queue_drained", q8.size(), 32'd0);
        chk("w2_queue_drained", q2.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
